pc_fetch_unit: RTL and testbench

//  Program-counter and next-PC stage directly upstream of the byte-addressed instruction

---
 rtl/pc_fetch_if.sv | 35 +++
 rtl/pc_fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_if.sv
// Handshake/bus bundle between the decode/ALU path and the PC fetch unit.
//   Redirect/control (datapath -> fetch): stall, branch_taken, branch_offset, jump,
//     jump_index, jump_reg, jr_target, halt_req
//   Status (fetch -> datapath/imem): pc_out, pc_plus4, fetch_valid, halted,
//     misaligned, range_fault
// modport master: the datapath side that issues redirects.
// modport slave:  the fetch unit itself.
interface pc_fetch_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jump_reg;
    logic [31:0] jr_target;
    logic        halt_req;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        halted;
    logic        misaligned;
    logic        range_fault;

    modport master (
        output stall, branch_taken, branch_offset, jump, jump_index, jump_reg, jr_target,
               halt_req,
        input  pc_out, pc_plus4, fetch_valid, halted, misaligned, range_fault
    );

    modport slave (
        input  stall, branch_taken, branch_offset, jump, jump_index, jump_reg, jr_target,
               halt_req,
        output pc_out, pc_plus4, fetch_valid, halted, misaligned, range_fault
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter / next-PC stage feeding the byte-addressed instruction memory.
// Selects sequential, branch, jump or jump-register next PC with stall, halt and a
// one-cycle boot state after reset. Faults (misaligned JR, out-of-range PC) are sticky.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; wins over everything, including HALT
//   bus    pc_fetch_if.slave (redirect inputs, PC and status outputs)
// Parameters:
//   RESET_PC   PC loaded on reset (word aligned)
//   MEM_BYTES  instruction memory size; every fetched PC must be below it
// Optional feature:
//   BRANCH_DELAY_SLOT_EN  when defined, an accepted redirect first steps to pc_plus4
//                         (delay slot) and lands on the target on the following update.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 256
) (
    input logic       clk,
    input logic       reset,
    pc_fetch_if.slave bus
);
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        misaligned_q, misaligned_d;
    logic        range_fault_q, range_fault_d;

    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] redirect_pc;
    logic [31:0] upd_pc;
    logic        jr_misaligned;

`ifdef BRANCH_DELAY_SLOT_EN
    logic        pending_q, pending_d;
    logic [31:0] pending_pc_q, pending_pc_d;
    logic        redirect;
`endif

    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc_plus4 + (bus.branch_offset << 2);
    assign jump_target   = {pc_plus4[31:28], bus.jump_index, 2'b00};
    assign jr_misaligned = bus.jump_reg && (bus.jr_target[1:0] != 2'b00);

    // Highest-priority redirect wins; falls back to the sequential PC.
    always_comb begin
        redirect_pc = pc_plus4;
        if (bus.jump_reg) begin
            redirect_pc = bus.jr_target & ~32'h3;
        end else if (bus.jump) begin
            redirect_pc = jump_target;
        end else if (bus.branch_taken) begin
            redirect_pc = branch_target;
        end
    end

`ifdef BRANCH_DELAY_SLOT_EN
    assign redirect = bus.jump_reg | bus.jump | bus.branch_taken;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        misaligned_d  = misaligned_q;
        range_fault_d = range_fault_q;
        upd_pc        = pc_plus4;
`ifdef BRANCH_DELAY_SLOT_EN
        pending_d     = pending_q;
        pending_pc_d  = pending_pc_q;
`endif

        unique case (state_q)
            StBoot: begin
                state_d = StRun;
            end
            StRun: begin
                if (bus.halt_req) begin
                    state_d = StHalt;
`ifdef BRANCH_DELAY_SLOT_EN
                    pending_d = 1'b0;
`endif
                end else if (!bus.stall) begin
`ifdef BRANCH_DELAY_SLOT_EN
                    if (pending_q) begin
                        // Delay slot already executed: land on the stored target.
                        upd_pc    = pending_pc_q;
                        pending_d = 1'b0;
                    end else begin
                        upd_pc = pc_plus4;
                        if (redirect) begin
                            pending_d    = 1'b1;
                            pending_pc_d = redirect_pc;
                            if (jr_misaligned) begin
                                misaligned_d = 1'b1;
                            end
                        end
                    end
`else
                    upd_pc = redirect_pc;
                    if (jr_misaligned) begin
                        misaligned_d = 1'b1;
                    end
`endif
                    if (upd_pc >= MEM_LIMIT) begin
                        // PC is frozen at the last good fetch address.
                        range_fault_d = 1'b1;
                        state_d       = StHalt;
`ifdef BRANCH_DELAY_SLOT_EN
                        pending_d     = 1'b0;
`endif
                    end else begin
                        pc_d = upd_pc;
                    end
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StBoot;
            pc_q          <= RESET_PC;
            misaligned_q  <= 1'b0;
            range_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            misaligned_q  <= misaligned_d;
            range_fault_q <= range_fault_d;
        end
    end

`ifdef BRANCH_DELAY_SLOT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q    <= 1'b0;
            pending_pc_q <= 32'h0;
        end else begin
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
        end
    end
`endif

    assign bus.pc_out      = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.fetch_valid = (state_q == StRun);
    assign bus.halted      = (state_q == StHalt);
    assign bus.misaligned  = misaligned_q;
    assign bus.range_fault = range_fault_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;
    localparam int unsigned MEM = 256;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    pc_fetch_if tif ();

    pc_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .MEM_BYTES(MEM)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (tif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: architectural PC, a named mode and the sticky flags.
    string       m_mode;
    logic [31:0] m_pc;
    bit          m_mis;
    bit          m_rf;
    bit          m_pend;
    logic [31:0] m_pend_pc;

    function automatic logic [67:0] expv();
        return {m_pc, m_pc + 32'd4, m_mode == "RUN", m_mode == "HALT", m_mis, m_rf};
    endfunction

    function automatic logic [67:0] obs();
        return {tif.pc_out, tif.pc_plus4, tif.fetch_valid, tif.halted, tif.misaligned,
                tif.range_fault};
    endfunction

    task automatic model_step();
        logic [31:0] seq;
        logic [31:0] tgt;
        logic [31:0] nxt;
        bit          redir;
        if (reset) begin
            m_mode = "BOOT"; m_pc = 32'h0; m_mis = 0; m_rf = 0; m_pend = 0;
            return;
        end
        seq = m_pc + 32'd4;
        if (m_mode == "BOOT") begin
            m_mode = "RUN";
        end else if (m_mode == "RUN") begin
            if (tif.halt_req) begin
                m_mode = "HALT";
                m_pend = 0;
            end else if (!tif.stall) begin
                redir = 1;
                if (tif.jump_reg)          tgt = tif.jr_target - (tif.jr_target % 4);
                else if (tif.jump)         tgt = (seq & 32'hF000_0000) + tif.jump_index * 4;
                else if (tif.branch_taken) tgt = seq + tif.branch_offset * 4;
                else begin
                    redir = 0;
                    tgt   = seq;
                end
`ifdef BRANCH_DELAY_SLOT_EN
                if (m_pend) begin
                    nxt    = m_pend_pc;
                    m_pend = 0;
                end else begin
                    nxt = seq;
                    if (redir) begin
                        m_pend    = 1;
                        m_pend_pc = tgt;
                        if (tif.jump_reg && tif.jr_target % 4 != 0) m_mis = 1;
                    end
                end
`else
                nxt = tgt;
                if (tif.jump_reg && tif.jr_target % 4 != 0) m_mis = 1;
                if (redir) nxt = tgt;
`endif
                if (nxt >= MEM) begin
                    m_rf   = 1;
                    m_mode = "HALT";
                    m_pend = 0;
                end else begin
                    m_pc = nxt;
                end
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        tif.stall = 0; tif.branch_taken = 0; tif.branch_offset = 0; tif.jump = 0;
        tif.jump_index = 0; tif.jump_reg = 0; tif.jr_target = 0; tif.halt_req = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        cycle();
        reset = 0;
    endtask

    task automatic run_to(input logic [31:0] addr);
        for (int i = 0; i < 200 && m_pc != addr; i++) cycle();
        n_checks++;
        if (tif.pc_out !== addr) begin
            n_fail++;
            $display("FAIL run_to: pc_out=%h, required %h", tif.pc_out, addr);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (obs() !== expv() || tif.fetch_valid !== 1'b0 || tif.pc_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h, required %h", obs(), expv());
        end
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++;
            if (obs() !== expv() || tif.pc_out !== 32'(i == 0 ? 0 : 4 * i)) begin
                n_fail++;
                $display("FAIL sequential %0d: got %h, required %h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_branch();
        do_reset();
        run_to(32'h8);
        tif.branch_taken = 1; tif.branch_offset = 32'hFFFF_FFFE;
        cycle();
        clear_inputs();
        n_checks++;
        if (obs() !== expv()) begin
            n_fail++;
            $display("FAIL branch_back: got %h, required %h", obs(), expv());
        end
`ifndef BRANCH_DELAY_SLOT_EN
        n_checks++;
        if (tif.pc_out !== 32'h4) begin
            n_fail++;
            $display("FAIL branch_back_pc: pc_out=%h, required 4", tif.pc_out);
        end
`endif
        run_to(32'h8);
        tif.branch_taken = 1; tif.branch_offset = 32'd3;
        cycle();
        clear_inputs();
        n_checks++;
        if (obs() !== expv()) begin
            n_fail++;
            $display("FAIL branch_fwd: got %h, required %h", obs(), expv());
        end
`ifndef BRANCH_DELAY_SLOT_EN
        n_checks++;
        if (tif.pc_out !== 32'h18) begin
            n_fail++;
            $display("FAIL branch_fwd_pc: pc_out=%h, required 18", tif.pc_out);
        end
`endif
    endtask

    task automatic test_jump();
        do_reset();
        run_to(32'h10);
        tif.jump = 1; tif.jump_index = 26'h5;
        cycle();
        clear_inputs();
        tif.jump_reg = 1; tif.jr_target = 32'h22;
        cycle();
        clear_inputs();
        n_checks++;
        if (obs() !== expv()) begin
            n_fail++;
            $display("FAIL jump_jr: got %h, required %h", obs(), expv());
        end
`ifndef BRANCH_DELAY_SLOT_EN
        n_checks++;
        if (tif.pc_out !== 32'h20 || tif.misaligned !== 1'b1) begin
            n_fail++;
            $display("FAIL jr_target: pc_out=%h mis=%b, required 20 and 1", tif.pc_out,
                     tif.misaligned);
        end
`endif
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL misaligned_sticky: got %h, required %h", obs(), expv());
            end
        end
    endtask

    task automatic test_stall_priority();
        do_reset();
        run_to(32'hC);
        tif.stall = 1; tif.branch_taken = 1; tif.branch_offset = 32'd5;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (obs() !== expv() || tif.pc_out !== 32'hC) begin
                n_fail++;
                $display("FAIL stall_hold: got %h, required %h", obs(), expv());
            end
        end
        tif.stall = 0; tif.jump = 1; tif.jump_index = 26'h8; tif.branch_offset = 32'd1;
        cycle();
        clear_inputs();
        n_checks++;
        if (obs() !== expv()) begin
            n_fail++;
            $display("FAIL jump_over_branch: got %h, required %h", obs(), expv());
        end
`ifndef BRANCH_DELAY_SLOT_EN
        n_checks++;
        if (tif.pc_out !== 32'h20) begin
            n_fail++;
            $display("FAIL jump_wins_pc: pc_out=%h, required 20", tif.pc_out);
        end
`endif
    endtask

    task automatic test_range_halt();
        do_reset();
        run_to(32'hFC);
        cycle();
        n_checks++;
        if (obs() !== expv() || tif.pc_out !== 32'hFC || tif.range_fault !== 1'b1 ||
            tif.halted !== 1'b1) begin
            n_fail++;
            $display("FAIL range_fault: got %h, required %h", obs(), expv());
        end
        tif.jump = 1; tif.jump_index = 26'h1;
        cycle();
        clear_inputs();
        n_checks++;
        if (obs() !== expv()) begin
            n_fail++;
            $display("FAIL halt_ignores_redirect: got %h, required %h", obs(), expv());
        end
        do_reset();
        n_checks++;
        if (obs() !== expv() || tif.pc_out !== 32'h0 || tif.halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_from_halt: got %h, required %h", obs(), expv());
        end
        run_to(32'h40);
        tif.halt_req = 1; tif.jump = 1; tif.jump_index = 26'h2;
        cycle();
        clear_inputs();
        cycle();
        n_checks++;
        if (obs() !== expv() || tif.pc_out !== 32'h40 || tif.halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_req: got %h, required %h", obs(), expv());
        end
    endtask

`ifdef BRANCH_DELAY_SLOT_EN
    task automatic test_delay_slot();
        logic [31:0] want [3];
        want[0] = 32'hC; want[1] = 32'hC; want[2] = 32'h40;
        do_reset();
        run_to(32'h8);
        tif.branch_taken = 1; tif.branch_offset = 32'd13;
        cycle();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) tif.stall = 1;
            if (i > 0) cycle();
            tif.stall = 0;
            n_checks++;
            if (obs() !== expv() || tif.pc_out !== want[i]) begin
                n_fail++;
                $display("FAIL delay_slot %0d: got %h, required %h", i, obs(), expv());
            end
        end
        cycle();
        n_checks++;
        if (tif.pc_out !== 32'h44) begin
            n_fail++;
            $display("FAIL delay_slot_after: pc_out=%h, required 44", tif.pc_out);
        end
    endtask
`endif

    task automatic test_random();
        for (int ep = 0; ep < 10; ep++) begin
            do_reset();
            for (int i = 0; i < 40; i++) begin
                tif.stall         = ($urandom_range(0, 5) == 0);
                tif.branch_taken  = ($urandom_range(0, 4) == 0);
                tif.branch_offset = 32'($urandom_range(0, 15)) - 32'd8;
                tif.jump          = ($urandom_range(0, 7) == 0);
                tif.jump_index    = 26'($urandom_range(0, 70));
                tif.jump_reg      = ($urandom_range(0, 9) == 0);
                tif.jr_target     = 32'($urandom_range(0, 300));
                tif.halt_req      = ($urandom_range(0, 59) == 0);
                reset             = ($urandom_range(0, 79) == 0);
                cycle();
                n_checks++;
                if (obs() !== expv()) begin
                    n_fail++;
                    $display("FAIL random ep%0d cyc%0d: got %h, required %h", ep, i, obs(),
                             expv());
                end
            end
            reset = 0;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1;
        clear_inputs();
        m_mode = "BOOT"; m_pc = 0; m_mis = 0; m_rf = 0; m_pend = 0; m_pend_pc = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_branch();
        test_jump();
        test_stall_priority();
        test_range_halt();
`ifdef BRANCH_DELAY_SLOT_EN
        test_delay_slot();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
